// File: rtl/wb_gpio_pkg.sv
// wb_gpio_ctrl shared definitions.
// Register offsets, data width and byte-lane merge helper.
package wb_gpio_pkg;

  localparam int REG_W = 32;

  localparam logic [7:0] OFS_IN   = 8'h00;
  localparam logic [7:0] OFS_OUT  = 8'h04;
  localparam logic [7:0] OFS_DIR  = 8'h08;
  localparam logic [7:0] OFS_SET  = 8'h0C;
  localparam logic [7:0] OFS_CLR  = 8'h10;
  localparam logic [7:0] OFS_IER  = 8'h14;
  localparam logic [7:0] OFS_IEF  = 8'h18;
  localparam logic [7:0] OFS_STAT = 8'h1C;

  // Take new_v bytes where sel is set, keep old_v bytes elsewhere.
  function automatic logic [REG_W-1:0] lane_merge(
    input logic [REG_W-1:0] old_v,
    input logic [REG_W-1:0] new_v,
    input logic [3:0]       sel
  );
    logic [REG_W-1:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin input synchroniser with edge detection.
// A SYNC_STAGES flop chain per pin followed by one history flop.
module gpio_sync_edge #(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [GPIO_W-1:0] pin_i,
  output logic [GPIO_W-1:0] sync_o,
  output logic [GPIO_W-1:0] rise_o,
  output logic [GPIO_W-1:0] fall_o
);

  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] prev_q;

  // Shift pins through the chain; remember last synchronised value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// Wishbone classic GPIO controller.
// Direction, set/clear, synchronised inputs and edge interrupts.
module wb_gpio_ctrl
  import wb_gpio_pkg::*;
#(
  parameter int          GPIO_W      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [31:0]       ADR_I,
  input  logic [31:0]       DAT_I,
  output logic [31:0]       DAT_O,
  input  logic              WE_I,
  input  logic [3:0]        SEL_I,
  input  logic              STB_I,
  input  logic              CYC_I,
  output logic              ACK_O,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq_o
);

  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] dir_q, dir_d;
  logic [GPIO_W-1:0] ier_q, ier_d;
  logic [GPIO_W-1:0] ief_q, ief_d;
  logic [GPIO_W-1:0] stat_q, stat_d;
  logic [REG_W-1:0]  dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              irq_q, irq_d;

  logic [GPIO_W-1:0] sync, rise, fall;
  logic [GPIO_W-1:0] msk, wdat, hw_set, w1c;
  logic [REG_W-1:0]  lane_m, rdata;
  logic              sel, acc;
  logic              unused_ok;

  gpio_sync_edge #(
    .GPIO_W     (GPIO_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (CLK_I),
    .rst_i (RST_I),
    .pin_i (gpio_i),
    .sync_o(sync),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign sel    = CYC_I & STB_I & (ADR_I[31:8] == BASE_ADDR[31:8]);
  assign acc    = sel & ~ack_q;
  assign lane_m = lane_merge('0, '1, SEL_I);
  assign msk    = lane_m[GPIO_W-1:0];
  assign wdat   = DAT_I[GPIO_W-1:0] & msk;
  assign hw_set = (rise & ier_q) | (fall & ief_q);

  // Bits above the pin count are dropped on purpose.
  assign unused_ok = ^{DAT_I, lane_m};

  // Read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rdata = '0;
    case (ADR_I[7:0])
      OFS_IN:   rdata = REG_W'(sync);
      OFS_OUT:  rdata = REG_W'(out_q);
      OFS_DIR:  rdata = REG_W'(dir_q);
      OFS_IER:  rdata = REG_W'(ier_q);
      OFS_IEF:  rdata = REG_W'(ief_q);
      OFS_STAT: rdata = REG_W'(stat_q);
      default:  rdata = '0;
    endcase
  end

  // Next state: register writes, W1C with hardware set winning.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    ier_d = ier_q;
    ief_d = ief_q;
    w1c   = '0;
    if (acc & WE_I) begin
      case (ADR_I[7:0])
        OFS_OUT:  out_d = (out_q & ~msk) | wdat;
        OFS_DIR:  dir_d = (dir_q & ~msk) | wdat;
        OFS_SET:  out_d = out_q | wdat;
        OFS_CLR:  out_d = out_q & ~wdat;
        OFS_IER:  ier_d = (ier_q & ~msk) | wdat;
        OFS_IEF:  ief_d = (ief_q & ~msk) | wdat;
        OFS_STAT: w1c = wdat;
        default:  ;
      endcase
    end
    stat_d = (stat_q & ~w1c) | hw_set;
    dat_d  = (acc & ~WE_I) ? rdata : dat_q;
    ack_d  = acc;
    irq_d  = |stat_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      out_q  <= '0;
      dir_q  <= '0;
      ier_q  <= '0;
      ief_q  <= '0;
      stat_q <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      ier_q  <= ier_d;
      ief_q  <= ief_d;
      stat_q <= stat_d;
      dat_q  <= dat_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
    end
  end

  assign DAT_O   = dat_q;
  assign ACK_O   = ack_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Self-checking bench for wb_gpio_ctrl.
// Directed plan steps then random traffic against a reference model.
module tb_wb_gpio_ctrl;

  localparam int          W    = 16;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'h0000_0200;
  localparam logic [31:0] PM   = 32'h0000_FFFF;

  logic          clk;
  logic          RST_I;
  logic [31:0]   ADR_I, DAT_I, DAT_O;
  logic          WE_I, STB_I, CYC_I, ACK_O, irq_o;
  logic [3:0]    SEL_I;
  logic [W-1:0]  gpio_i, gpio_o, gpio_oe;

  int checks;
  int failures;

  wb_gpio_ctrl #(
    .GPIO_W     (W),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(S)
  ) dut (
    .CLK_I  (clk),
    .RST_I  (RST_I),
    .ADR_I  (ADR_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .WE_I   (WE_I),
    .SEL_I  (SEL_I),
    .STB_I  (STB_I),
    .CYC_I  (CYC_I),
    .ACK_O  (ACK_O),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .irq_o  (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: hist[j] is gpio_i sampled j edges ago.
  logic [31:0] m_out, m_dir, m_ier, m_ief, m_stat, m_dat;
  logic        m_ack, m_irq;
  logic [31:0] hist[$];

  always @(posedge clk) begin : model
    logic [31:0] syn, prv, hs, lm, d, w1c, rv;
    logic        acc;
    if (RST_I) begin
      m_out = 0; m_dir = 0; m_ier = 0; m_ief = 0;
      m_stat = 0; m_dat = 0; m_ack = 0; m_irq = 0;
      hist.delete();
      repeat (S + 1) hist.push_back(32'h0);
    end else begin
      hist.push_front(32'(gpio_i));
      syn = hist[S];
      prv = hist[S+1];
      hs  = (syn & ~prv & m_ier) | (~syn & prv & m_ief);
      acc = CYC_I && STB_I && (ADR_I[31:8] == BASE[31:8]) && !m_ack;
      lm  = 0;
      for (int k = 0; k < 4; k++)
        if (SEL_I[k]) lm[8*k +: 8] = 8'hFF;
      lm  = lm & PM;
      d   = DAT_I & lm;
      w1c = 0;
      rv  = 0;
      case (ADR_I[7:0])
        8'h00: rv = syn;
        8'h04: rv = m_out;
        8'h08: rv = m_dir;
        8'h14: rv = m_ier;
        8'h18: rv = m_ief;
        8'h1C: rv = m_stat;
        default: rv = 0;
      endcase
      if (acc && WE_I) begin
        case (ADR_I[7:0])
          8'h04: m_out = (m_out & ~lm) | d;
          8'h08: m_dir = (m_dir & ~lm) | d;
          8'h0C: m_out = m_out | d;
          8'h10: m_out = m_out & ~d;
          8'h14: m_ier = (m_ier & ~lm) | d;
          8'h18: m_ief = (m_ief & ~lm) | d;
          8'h1C: w1c = d;
          default: ;
        endcase
      end
      if (acc && !WE_I) m_dat = rv;
      m_irq  = (m_stat != 0);
      m_stat = (m_stat & ~w1c) | hs;
      m_ack  = acc;
      void'(hist.pop_back());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("ack",  32'(ACK_O),   32'(m_ack));
    chk("dato", DAT_O,        m_dat);
    chk("gpo",  32'(gpio_o),  m_out);
    chk("oe",   32'(gpio_oe), m_dir);
    chk("irq",  32'(irq_o),   32'(m_irq));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check_model();
    end
  endtask

  // Called at a negedge; single-cycle strobe, returns at a negedge.
  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic [3:0] s,
                     input logic exp_ack, output logic [31:0] r);
    ADR_I = a; DAT_I = d; WE_I = we; SEL_I = s;
    CYC_I = 1'b1; STB_I = 1'b1;
    @(negedge clk);
    check_model();
    chk("ack_lat", 32'(ACK_O), 32'(exp_ack));
    r = DAT_O;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(negedge clk);
    check_model();
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    bus(BASE + 32'(o), d, 1'b1, s, 1'b1, r);
  endtask

  task automatic rd(input logic [7:0] o, input logic [31:0] exp,
                    input string tag);
    logic [31:0] r;
    bus(BASE + 32'(o), 32'h0, 1'b0, 4'hF, 1'b1, r);
    chk(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r, a;
    logic        ea;
    checks = 0; failures = 0;
    RST_I = 1'b1; ADR_I = 0; DAT_I = 0; WE_I = 0; SEL_I = 0;
    STB_I = 0; CYC_I = 0; gpio_i = '0;
    repeat (3) @(negedge clk);
    RST_I = 1'b0;
    chk("rst_ack",  32'(ACK_O),   32'h0);
    chk("rst_dato", DAT_O,        32'h0);
    chk("rst_gpo",  32'(gpio_o),  32'h0);
    chk("rst_oe",   32'(gpio_oe), 32'h0);
    chk("rst_irq",  32'(irq_o),   32'h0);

    for (int i = 0; i < 8; i++) rd(8'(4 * i), 32'h0, "rd_reset");
    chk("irq_idle", 32'(irq_o), 32'h0);

    wr(8'h04, 32'h0000_00A5, 4'b0001);
    wr(8'h0C, 32'h0000_0F00, 4'hF);
    wr(8'h10, 32'h0000_0005, 4'hF);
    chk("gpo_setclr", 32'(gpio_o), 32'h0000_0FA0);
    rd(8'h04, 32'h0000_0FA0, "rd_out");
    rd(8'h0C, 32'h0, "rd_set");

    wr(8'h08, 32'h0000_FFFF, 4'hF);
    chk("oe_all", 32'(gpio_oe), 32'h0000_FFFF);
    gpio_i = 16'h1234;
    rd(8'h00, 32'h0, "in_early");
    rd(8'h00, 32'h0000_1234, "in_sync");

    wr(8'h14, 32'h1, 4'hF);
    gpio_i = 16'h1235;
    tick(3);
    chk("irq_pre", 32'(irq_o), 32'h0);
    tick(1);
    chk("irq_lat", 32'(irq_o), 32'h1);
    rd(8'h1C, 32'h1, "stat_rise");
    wr(8'h1C, 32'h1, 4'hF);
    chk("irq_clr", 32'(irq_o), 32'h0);
    gpio_i = 16'h1234;
    tick(6);
    chk("irq_fall", 32'(irq_o), 32'h0);
    rd(8'h1C, 32'h0, "stat_fall");

    wr(8'h14, 32'h9, 4'hF);
    gpio_i = 16'h123C;
    tick(5);
    gpio_i = 16'h1234;
    tick(4);
    rd(8'h1C, 32'h8, "stat_p3");
    gpio_i = 16'h123C;
    tick(2);
    wr(8'h1C, 32'h8, 4'hF);
    chk("irq_setwin", 32'(irq_o), 32'h1);
    rd(8'h1C, 32'h8, "stat_setwin");
    wr(8'h1C, 32'h8, 4'b0010);
    rd(8'h1C, 32'h8, "stat_lane");
    wr(8'h1C, 32'h8, 4'b0001);
    tick(1);
    chk("irq_w1c", 32'(irq_o), 32'h0);

    ADR_I = BASE + 32'h8; WE_I = 0; SEL_I = 4'hF;
    CYC_I = 1; STB_I = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_model();
      chk("held_ack", 32'(ACK_O), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    CYC_I = 0; STB_I = 0;
    tick(1);

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        8:       a = BASE + 32'($urandom_range(0, 255));
        9:       a = 32'h0000_0300 + 32'($urandom_range(0, 31));
        default: a = BASE + 32'(4 * $urandom_range(0, 7));
      endcase
      ea = (a[31:8] == BASE[31:8]);
      if ($urandom_range(0, 1) == 1) gpio_i = gpio_i ^ 16'($urandom());
      bus(a, $urandom(), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), ea, r);
      tick($urandom_range(0, 3));
    end

    wr(8'h04, 32'h0, 4'hF);
    ADR_I = BASE + 32'h4; DAT_I = 32'h0000_FFFF; WE_I = 1;
    SEL_I = 4'hF; CYC_I = 1; STB_I = 1; RST_I = 1;
    @(negedge clk);
    chk("rst_mid_ack", 32'(ACK_O), 32'h0);
    chk("rst_mid_gpo", 32'(gpio_o), 32'h0);
    CYC_I = 0; STB_I = 0; WE_I = 0; RST_I = 0;
    tick(2);
    chk("rst_mid_gpo2", 32'(gpio_o), 32'h0);
    bus(32'h0000_0300, 32'h0, 1'b0, 4'hF, 1'b0, r);
    bus(32'h0000_0304, 32'hFFFF, 1'b1, 4'hF, 1'b0, r);
    chk("nobase_gpo", 32'(gpio_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
